// File: rtl/coms_multi.sv
// coms_multi: RS485 frame handler serving NUM_MOTORS channels behind one base ID.
// Define COMS_ACK_EN to acknowledge accepted SETPOINT/CONFIG frames with a 7-byte ack.
module coms_multi #(
    parameter int NUM_MOTORS      = 4,
    parameter int TIMEOUT_CYCLES  = 16000,
    parameter int KP_RESET        = 10,
    parameter int PWM_LIMIT_RESET = 500
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [7:0]               ID,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_ready,
    output logic                     driver_enable,
    input  logic [NUM_MOTORS*24-1:0] position,
    input  logic [NUM_MOTORS*16-1:0] current,
    output logic [NUM_MOTORS*24-1:0] setpoint,
    output logic [NUM_MOTORS*8-1:0]  control_mode,
    output logic [NUM_MOTORS*16-1:0] Kp,
    output logic [NUM_MOTORS*16-1:0] Ki,
    output logic [NUM_MOTORS*16-1:0] Kd,
    output logic [NUM_MOTORS*24-1:0] pwm_limit,
    output logic [15:0]              err_count
);

    localparam int IDX_W   = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int SET_LEN = 3 * NUM_MOTORS + 3;
    localparam int PAY_MAX = (SET_LEN > 13) ? SET_LEN : 13;
    localparam int CNT_W   = $clog2(PAY_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0] MAGIC_STATUS   = 32'h1CE1CEBB;
    localparam logic [31:0] MAGIC_SETPOINT = 32'hD0D0D0D0;
    localparam logic [31:0] MAGIC_CONFIG   = 32'hBAADA555;

    // Position of the CRC high byte and of the final byte within each payload.
    localparam logic [CNT_W-1:0] ST_CRC  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] SP_CRC  = CNT_W'(SET_LEN - 2);
    localparam logic [CNT_W-1:0] SP_LAST = CNT_W'(SET_LEN - 1);
    localparam logic [CNT_W-1:0] CF_CRC  = CNT_W'(11);
    localparam logic [CNT_W-1:0] CF_LAST = CNT_W'(12);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       NUM_M8   = 8'(NUM_MOTORS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_PAYLOAD,
        S_CHECK,
        S_LOAD_RESP,
`ifdef COMS_ACK_EN
        S_LOAD_ACK,
`endif
        S_SEND
    } state_e;

    typedef enum logic [1:0] {F_STATUS, F_SETPOINT, F_CONFIG} frame_e;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_e             state_q, state_d;
    frame_e             frame_q, frame_d;
    logic [31:0]        magic_q, magic_d;
    logic [15:0]        crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         tx_idx_q, tx_idx_d;
    logic [3:0]         tx_last_q, tx_last_d;
    logic               tx_valid_q, tx_valid_d;
    logic               drv_q, drv_d;

    logic [7:0]         pay_q [PAY_MAX];
    logic [7:0]         pay_d [PAY_MAX];
    logic [7:0]         resp_q [16];
    logic [7:0]         resp_d [16];

    logic [23:0]        sp_q   [NUM_MOTORS];
    logic [23:0]        sp_d   [NUM_MOTORS];
    logic [7:0]         mode_q [NUM_MOTORS];
    logic [7:0]         mode_d [NUM_MOTORS];
    logic [15:0]        kp_q   [NUM_MOTORS];
    logic [15:0]        kp_d   [NUM_MOTORS];
    logic [15:0]        ki_q   [NUM_MOTORS];
    logic [15:0]        ki_d   [NUM_MOTORS];
    logic [15:0]        kd_q   [NUM_MOTORS];
    logic [15:0]        kd_d   [NUM_MOTORS];
    logic [23:0]        pwm_q  [NUM_MOTORS];
    logic [23:0]        pwm_d  [NUM_MOTORS];

    logic [23:0]        pos_a  [NUM_MOTORS];
    logic [15:0]        cur_a  [NUM_MOTORS];

    logic               magic_hit;
    frame_e             magic_frame;
    logic [CNT_W-1:0]   crc_pos, last_pos;
    logic [7:0]         id_diff;
    logic               crc_ok, addr_ok;
    logic [IDX_W-1:0]   addr_idx;
    logic [15:0]        resp_crc;
    logic               err_inc;

    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_ch
        assign pos_a[k]                  = position[24*k +: 24];
        assign cur_a[k]                  = current[16*k +: 16];
        assign setpoint[24*k +: 24]      = sp_q[k];
        assign control_mode[8*k +: 8]    = mode_q[k];
        assign Kp[16*k +: 16]            = kp_q[k];
        assign Ki[16*k +: 16]            = ki_q[k];
        assign Kd[16*k +: 16]            = kd_q[k];
        assign pwm_limit[24*k +: 24]     = pwm_q[k];
    end

    always_comb begin
        magic_hit   = 1'b1;
        magic_frame = F_STATUS;
        case (magic_q)
            MAGIC_STATUS:   magic_frame = F_STATUS;
            MAGIC_SETPOINT: magic_frame = F_SETPOINT;
            MAGIC_CONFIG:   magic_frame = F_CONFIG;
            default:        magic_hit   = 1'b0;
        endcase
    end

    always_comb begin
        crc_pos  = ST_CRC;
        last_pos = ST_LAST;
        case (frame_q)
            F_SETPOINT: begin crc_pos = SP_CRC; last_pos = SP_LAST; end
            F_CONFIG:   begin crc_pos = CF_CRC; last_pos = CF_LAST; end
            default:    ;
        endcase
    end

    // Channel index is the 8-bit wrapped distance from the base ID.
    assign id_diff  = pay_q[0] - ID;
    assign addr_idx = id_diff[IDX_W-1:0];
    assign crc_ok   = ({pay_q[crc_pos], pay_q[last_pos]} == crc_q);
    assign addr_ok  = (frame_q == F_SETPOINT) ? (pay_q[0] == ID) : (id_diff < NUM_M8);

    // NOTE: every _d is given its _q value first, so no branch can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        magic_d    = magic_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        idx_d      = idx_q;
        tx_idx_d   = tx_idx_q;
        tx_last_d  = tx_last_q;
        tx_valid_d = tx_valid_q;
        drv_d      = drv_q;
        pay_d      = pay_q;
        resp_d     = resp_q;
        sp_d       = sp_q;
        mode_d     = mode_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        pwm_d      = pwm_q;
        resp_crc   = 16'hFFFF;
        err_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (magic_hit) begin
                    magic_d = '0;
                    crc_d   = 16'hFFFF;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    frame_d = magic_frame;
                    state_d = S_RX_PAYLOAD;
                end else if (rx_valid) begin
                    magic_d = {magic_q[23:0], rx_data};
                end
            end

            S_RX_PAYLOAD: begin
                if (rx_valid) begin
                    pay_d[cnt_q] = rx_data;
                    cnt_d        = cnt_q + 1'b1;
                    tmo_d        = '0;
                    if (cnt_q < crc_pos)   crc_d   = crc16_step(crc_q, rx_data);
                    if (cnt_q == last_pos) state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_CHECK: begin
                state_d = S_IDLE;
                if (rx_valid) magic_d = {magic_q[23:0], rx_data};
                if (!crc_ok) begin
                    err_inc = 1'b1;
                end else if (addr_ok) begin
                    case (frame_q)
                        F_STATUS: begin
                            idx_d   = addr_idx;
                            state_d = S_LOAD_RESP;
                        end
                        F_CONFIG: begin
                            mode_d[addr_idx] = pay_q[1];
                            kp_d[addr_idx]   = {pay_q[2], pay_q[3]};
                            ki_d[addr_idx]   = {pay_q[4], pay_q[5]};
                            kd_d[addr_idx]   = {pay_q[6], pay_q[7]};
                            pwm_d[addr_idx]  = {pay_q[8], pay_q[9], pay_q[10]};
`ifdef COMS_ACK_EN
                            state_d = S_LOAD_ACK;
`endif
                        end
                        default: begin
                            for (int k = 0; k < NUM_MOTORS; k++)
                                sp_d[k] = {pay_q[1+3*k], pay_q[2+3*k], pay_q[3+3*k]};
`ifdef COMS_ACK_EN
                            state_d = S_LOAD_ACK;
`endif
                        end
                    endcase
                end
            end

            S_LOAD_RESP: begin
                resp_d[0] = 8'h1C;
                resp_d[1] = 8'hEB;
                resp_d[2] = 8'h00;
                resp_d[3] = 8'hDA;
                resp_d[4] = pay_q[0];
                resp_d[5] = mode_q[idx_q];
                {resp_d[6], resp_d[7], resp_d[8]}  = pos_a[idx_q];
                {resp_d[9], resp_d[10], resp_d[11]} = sp_q[idx_q];
                {resp_d[12], resp_d[13]}           = cur_a[idx_q];
                for (int i = 4; i < 14; i++) resp_crc = crc16_step(resp_crc, resp_d[i]);
                {resp_d[14], resp_d[15]} = resp_crc;
                tx_idx_d   = '0;
                tx_last_d  = 4'd15;
                tx_valid_d = 1'b1;
                drv_d      = 1'b1;
                state_d    = S_SEND;
            end

`ifdef COMS_ACK_EN
            S_LOAD_ACK: begin
                resp_d[0] = 8'hAC;
                resp_d[1] = 8'hCE;
                resp_d[2] = 8'h55;
                resp_d[3] = 8'hED;
                resp_d[4] = pay_q[0];
                resp_crc  = crc16_step(16'hFFFF, pay_q[0]);
                {resp_d[5], resp_d[6]} = resp_crc;
                tx_idx_d   = '0;
                tx_last_d  = 4'd6;
                tx_valid_d = 1'b1;
                drv_d      = 1'b1;
                state_d    = S_SEND;
            end
`endif

            S_SEND: begin
                // No timeout here: a stalled UART holds the current byte forever.
                if (tx_ready) begin
                    if (tx_idx_q == tx_last_q) begin
                        tx_valid_d = 1'b0;
                        drv_d      = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            frame_q    <= F_STATUS;
            magic_q    <= '0;
            crc_q      <= 16'hFFFF;
            cnt_q      <= '0;
            tmo_q      <= '0;
            err_q      <= '0;
            idx_q      <= '0;
            tx_idx_q   <= '0;
            tx_last_q  <= '0;
            tx_valid_q <= 1'b0;
            drv_q      <= 1'b0;
            for (int k = 0; k < NUM_MOTORS; k++) begin
                sp_q[k]   <= '0;
                mode_q[k] <= '0;
                kp_q[k]   <= 16'(KP_RESET);
                ki_q[k]   <= '0;
                kd_q[k]   <= '0;
                pwm_q[k]  <= 24'(PWM_LIMIT_RESET);
            end
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            magic_q    <= magic_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            tx_idx_q   <= tx_idx_d;
            tx_last_q  <= tx_last_d;
            tx_valid_q <= tx_valid_d;
            drv_q      <= drv_d;
            sp_q       <= sp_d;
            mode_q     <= mode_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            pwm_q      <= pwm_d;
        end
    end

    // NOTE: byte buffers carry no reset; each is written for the current frame before it is read.
    always_ff @(posedge CLK) begin
        pay_q  <= pay_d;
        resp_q <= resp_d;
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = resp_q[tx_idx_q];
    assign driver_enable = drv_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_coms_multi.sv
// Directed testbench for coms_multi (4 channels, base ID 0x10); expected bytes built by the bench.
module tb_coms_multi;

    localparam int NM  = 4;
    localparam int TMO = 16000;

    logic              CLK = 1'b0;
    logic              reset;
    logic [7:0]        ID;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              driver_enable;
    logic [NM*24-1:0]  position;
    logic [NM*16-1:0]  current;
    logic [NM*24-1:0]  setpoint;
    logic [NM*8-1:0]   control_mode;
    logic [NM*16-1:0]  Kp, Ki, Kd;
    logic [NM*24-1:0]  pwm_limit;
    logic [15:0]       err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl [$];
    logic [7:0] got   [16];
    logic [7:0] exp_b [16];

    coms_multi #(.NUM_MOTORS(NM), .TIMEOUT_CYCLES(TMO), .KP_RESET(10), .PWM_LIMIT_RESET(500)) dut (
        .CLK(CLK), .reset(reset), .ID(ID),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .driver_enable(driver_enable),
        .position(position), .current(current),
        .setpoint(setpoint), .control_mode(control_mode),
        .Kp(Kp), .Ki(Ki), .Kd(Kd), .pwm_limit(pwm_limit),
        .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends magic + pl + CRC; returns one cycle after the last strobe (DUT in CHECK).
    task automatic send_frame(input logic [31:0] magic, input bit corrupt);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 3; i >= 0; i--) send_byte(magic[8*i +: 8], 1);
        foreach (pl[i]) begin
            c = crc_model(c, pl[i]);
            send_byte(pl[i], 1);
        end
        if (corrupt) c[0] = ~c[0];
        send_byte(c[15:8], 1);
        send_byte(c[7:0], 0);
    endtask

    task automatic build_status(input logic [7:0] id, input logic [7:0] mode,
                                input logic [23:0] pos, input logic [23:0] sp, input logic [15:0] cur);
        logic [15:0] c;
        exp_b[0] = 8'h1C; exp_b[1] = 8'hEB; exp_b[2] = 8'h00; exp_b[3] = 8'hDA;
        exp_b[4] = id;    exp_b[5] = mode;
        exp_b[6] = pos[23:16]; exp_b[7] = pos[15:8]; exp_b[8] = pos[7:0];
        exp_b[9] = sp[23:16];  exp_b[10] = sp[15:8]; exp_b[11] = sp[7:0];
        exp_b[12] = cur[15:8]; exp_b[13] = cur[7:0];
        c = 16'hFFFF;
        for (int i = 4; i < 14; i++) c = crc_model(c, exp_b[i]);
        exp_b[14] = c[15:8];
        exp_b[15] = c[7:0];
    endtask

    task automatic collect(input int first, input int last_n);
        int budget = 0;
        int n      = first;
        bit drv_ok = 1'b1;
        tx_ready = 1'b1;
        while (n < last_n && budget < 400) begin
            if (tx_valid) begin
                if (driver_enable !== 1'b1) drv_ok = 1'b0;
                got[n] = tx_data;
                n++;
            end
            tick();
            budget++;
        end
        checks++;
        if (n != last_n) begin
            errors++;
            $display("FAIL collect_count got %0d bytes exp %0d", n, last_n);
        end
        checks++;
        if (!drv_ok) begin
            errors++;
            $display("FAIL driver_enable_during_send got 0 exp 1");
        end
    endtask

    task automatic test_reset();
        checks++; if (setpoint !== '0) begin errors++; $display("FAIL rst_setpoint got %h exp 0", setpoint); end
        checks++; if (control_mode !== '0) begin errors++; $display("FAIL rst_mode got %h exp 0", control_mode); end
        checks++; if (Ki !== '0) begin errors++; $display("FAIL rst_ki got %h exp 0", Ki); end
        checks++; if (Kd !== '0) begin errors++; $display("FAIL rst_kd got %h exp 0", Kd); end
        checks++; if (Kp !== {4{16'd10}}) begin errors++; $display("FAIL rst_kp got %h exp %h", Kp, {4{16'd10}}); end
        checks++; if (pwm_limit !== {4{24'd500}}) begin errors++; $display("FAIL rst_pwm got %h exp %h", pwm_limit, {4{24'd500}}); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err got %h exp 0", err_count); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        checks++; if (driver_enable !== 1'b0) begin errors++; $display("FAIL rst_drv got %b exp 0", driver_enable); end
    endtask

    task automatic test_status();
        position[24*2 +: 24] = 24'h123456;
        current[16*2 +: 16]  = 16'hBEEF;
        build_status(8'h12, 8'h00, 24'h123456, 24'h000000, 16'hBEEF);
        pl = '{8'h12};
        tx_ready = 1'b1;
        send_frame(32'h1CE1CEBB, 1'b0);
        checks++; if (tx_valid !== 1'b0 || driver_enable !== 1'b0) begin
            errors++; $display("FAIL lat_check got %b%b exp 00", tx_valid, driver_enable); end
        tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL lat_load got %b exp 0", tx_valid); end
        tick();
        checks++; if (tx_valid !== 1'b1 || driver_enable !== 1'b1) begin
            errors++; $display("FAIL lat_send got %b%b exp 11", tx_valid, driver_enable); end
        collect(0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin errors++; $display("FAIL status_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
        checks++; if (tx_valid !== 1'b0 || driver_enable !== 1'b0) begin
            errors++; $display("FAIL status_end got %b%b exp 00", tx_valid, driver_enable); end
    endtask

    task automatic expect_write_reply(input logic [7:0] id, input bit accepted);
`ifdef COMS_ACK_EN
        if (accepted) begin
            logic [15:0] c;
            c = crc_model(16'hFFFF, id);
            exp_b[0] = 8'hAC; exp_b[1] = 8'hCE; exp_b[2] = 8'h55; exp_b[3] = 8'hED;
            exp_b[4] = id; exp_b[5] = c[15:8]; exp_b[6] = c[7:0];
            collect(0, 7);
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (got[i] !== exp_b[i]) begin errors++; $display("FAIL ack_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
            end
        end
`endif
        repeat (5) tick();
        checks++;
        if (tx_valid !== 1'b0 || driver_enable !== 1'b0) begin
            errors++; $display("FAIL write_quiet id %h acc %0d got %b%b exp 00", id, accepted, tx_valid, driver_enable);
        end
    endtask

    task automatic test_setpoint();
        pl = '{8'h10, 8'h00, 8'h00, 8'h64, 8'hFF, 8'hFF, 8'h9C, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'hFF};
        send_frame(32'hD0D0D0D0, 1'b0);
        checks++; if (setpoint !== '0) begin errors++; $display("FAIL sp_before got %h exp 0", setpoint); end
        tick();
        checks++;
        if (setpoint !== 96'h7FFFFF_000000_FFFF9C_000064) begin
            errors++; $display("FAIL sp_update got %h exp %h", setpoint, 96'h7FFFFF_000000_FFFF9C_000064);
        end
        expect_write_reply(8'h10, 1'b1);
        pl = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44};
        send_frame(32'hD0D0D0D0, 1'b1);
        tick();
        checks++;
        if (setpoint !== 96'h7FFFFF_000000_FFFF9C_000064) begin
            errors++; $display("FAIL sp_badcrc got %h exp %h", setpoint, 96'h7FFFFF_000000_FFFF9C_000064);
        end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL sp_badcrc_err got %0d exp 1", err_count); end
        expect_write_reply(8'h10, 1'b0);
    endtask

    task automatic test_config();
        pl = '{8'h13, 8'h02, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'h01, 8'h23, 8'h00, 8'h04, 8'h00};
        send_frame(32'hBAADA555, 1'b0);
        tick();
        checks++; if (control_mode !== 32'h02_00_00_00) begin errors++; $display("FAIL cfg_mode got %h exp 02000000", control_mode); end
        checks++; if (Kp !== 64'hD0D0_000A_000A_000A) begin errors++; $display("FAIL cfg_kp got %h exp D0D0000A000A000A", Kp); end
        checks++; if (Ki !== 64'hD0D0_0000_0000_0000) begin errors++; $display("FAIL cfg_ki got %h exp D0D0000000000000", Ki); end
        checks++; if (Kd !== 64'h0123_0000_0000_0000) begin errors++; $display("FAIL cfg_kd got %h exp 0123000000000000", Kd); end
        checks++;
        if (pwm_limit !== {24'h000400, 24'd500, 24'd500, 24'd500}) begin
            errors++; $display("FAIL cfg_pwm got %h exp %h", pwm_limit, {24'h000400, 24'd500, 24'd500, 24'd500});
        end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL cfg_err got %0d exp 1", err_count); end
        expect_write_reply(8'h13, 1'b1);
        pl = '{8'h14, 8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h00, 8'h00, 8'h01};
        send_frame(32'hBAADA555, 1'b0);
        tick();
        checks++; if (Kp !== 64'hD0D0_000A_000A_000A) begin errors++; $display("FAIL cfg_miss_kp got %h exp D0D0000A000A000A", Kp); end
        checks++; if (control_mode !== 32'h02_00_00_00) begin errors++; $display("FAIL cfg_miss_mode got %h exp 02000000", control_mode); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL cfg_miss_err got %0d exp 1", err_count); end
        expect_write_reply(8'h14, 1'b0);
    endtask

    task automatic test_timeout();
        logic [31:0] m;
        m = 32'h1CE1CEBB;
        for (int i = 3; i >= 0; i--) send_byte(m[8*i +: 8], 1);
        send_byte(8'h11, 1);
        repeat (TMO - 10) tick();
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL tmo_early got %0d exp 1", err_count); end
        repeat (20) tick();
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL tmo_abort got %0d exp 2", err_count); end
        position[24*1 +: 24] = 24'hABCDEF;
        current[16*1 +: 16]  = 16'h8001;
        build_status(8'h11, 8'h00, 24'hABCDEF, 24'hFFFF9C, 16'h8001);
        pl = '{8'h11};
        send_frame(32'h1CE1CEBB, 1'b0);
        collect(0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin errors++; $display("FAIL after_tmo_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_stall();
        bit stable = 1'b1;
        position[24*0 +: 24] = 24'hFEDCBA;
        current[16*0 +: 16]  = 16'h1234;
        build_status(8'h10, 8'h00, 24'hFEDCBA, 24'h000064, 16'h1234);
        pl = '{8'h10};
        send_frame(32'h1CE1CEBB, 1'b0);
        collect(0, 3);
        tx_ready = 1'b0;
        repeat (100) begin
            if (tx_valid !== 1'b1 || tx_data !== exp_b[3]) stable = 1'b0;
            tick();
        end
        checks++; if (!stable) begin errors++; $display("FAIL stall_hold got unstable exp byte %h held", exp_b[3]); end
        collect(3, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid_send();
        pl = '{8'h12};
        send_frame(32'h1CE1CEBB, 1'b0);
        collect(0, 2);
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || driver_enable !== 1'b0) begin
            errors++; $display("FAIL midsend_rst got %b%b exp 00", tx_valid, driver_enable); end
        checks++; if (setpoint !== '0) begin errors++; $display("FAIL midsend_rst_sp got %h exp 0", setpoint); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL midsend_rst_err got %0d exp 0", err_count); end
        @(negedge CLK);
        reset = 1'b0;
        repeat (20) tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_quiet got %b exp 0", tx_valid); end
    endtask

    initial begin
        reset    = 1'b1;
        ID       = 8'h10;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        position = '0;
        current  = '0;
        repeat (3) tick();
        @(negedge CLK);
        reset = 1'b0;
        tick();
        test_reset();
        test_status();
        test_setpoint();
        test_config();
        test_timeout();
        test_stall();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
